// File: rtl/sm_result_fifo.sv
// Result FIFO behind the state-machine accumulator, with a valid/ready drain and sticky overflow.
// Optional o_max port and register are enabled with `define SM_RESULT_FIFO_MAX_EN.
module sm_result_fifo #(
    parameter int DW    = 7,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_dval,
    input  logic [DW-1:0] i,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o,
    output logic [CW-1:0] o_count,
    output logic          overflow
`ifdef SM_RESULT_FIFO_MAX_EN
    ,
    output logic [DW-1:0] o_max
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          pop;
    logic          acc;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign pop   = !empty && o_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign acc   = i_dval && (!full || pop);

    assign o_valid = !empty;
    assign o       = mem[rp];
    assign o_count = cnt;

    always_ff @(posedge clk) begin
        if (rst && acc) begin
            mem[wp] <= i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (acc) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            if (acc && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !acc) begin
                cnt <= cnt - CW'(1);
            end
            if (i_dval && !acc) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef SM_RESULT_FIFO_MAX_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_max <= '0;
        end else if (acc && (i > o_max)) begin
            o_max <= i;
        end
    end
`endif

endmodule

// File: tb/tb_sm_result_fifo.sv
// Randomised and directed bench for sm_result_fifo against a queue model.
// o_max checks compile only with `define SM_RESULT_FIFO_MAX_EN.
module tb_sm_result_fifo;

    localparam int DW    = 7;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_dval = 1'b0;
    logic [DW-1:0] i = '0;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic [DW-1:0] o;
    logic [CW-1:0] o_count;
    logic          overflow;
`ifdef SM_RESULT_FIFO_MAX_EN
    logic [DW-1:0] o_max;
`endif

    sm_result_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .i_dval(i_dval),
        .i(i),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o(o),
        .o_count(o_count),
        .overflow(overflow)
`ifdef SM_RESULT_FIFO_MAX_EN
        ,
        .o_max(o_max)
`endif
    );

    always #5 clk = ~clk;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic [DW-1:0] m_max = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        check("o_valid", 32'(o_valid), 32'(q.size() != 0));
        check("o_count", 32'(o_count), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) check("o_data", 32'(o), 32'(q[0]));
`ifdef SM_RESULT_FIFO_MAX_EN
        check("o_max", 32'(o_max), 32'(m_max));
`endif
    endtask

    task automatic step(input logic dv, input logic [DW-1:0] d, input logic rdy);
        bit was_full;
        bit popped;
        i_dval  = dv;
        i       = d;
        o_ready = rdy;
        @(posedge clk);
        #1;
        was_full = (q.size() == DEPTH);
        popped   = (q.size() != 0) && rdy;
        if (popped) void'(q.pop_front());
        if (dv) begin
            if (!was_full || popped) begin
                q.push_back(d);
                if (d > m_max) m_max = d;
            end else begin
                m_ovf = 1'b1;
            end
        end
        i_dval  = 1'b0;
        o_ready = 1'b0;
        compare_all();
    endtask

    task automatic do_reset(input int cycles);
        rst    = 1'b0;
        i_dval = 1'b1;
        i      = 7'd99;
        repeat (cycles) @(posedge clk);
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_max = '0;
        rst    = 1'b1;
        i_dval = 1'b0;
        compare_all();
    endtask

    task automatic drain_expect(input string tag, input int n,
                                input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                                input logic [DW-1:0] v2, input logic [DW-1:0] v3);
        logic [DW-1:0] exp_v [4];
        exp_v[0] = v0;
        exp_v[1] = v1;
        exp_v[2] = v2;
        exp_v[3] = v3;
        for (int k = 0; k < n; k++) begin
            check(tag, 32'(o), 32'(exp_v[k]));
            step(1'b0, '0, 1'b1);
        end
        check({tag, "_empty"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        // Reset then idle
        do_reset(2);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        step(1'b0, '0, 1'b1);

        // Push then drain
        step(1'b1, 7'd5, 1'b0);
        step(1'b1, 7'd17, 1'b0);
        step(1'b1, 7'd100, 1'b0);
        check("p3_count", 32'(o_count), 32'd3);
        check("p3_head", 32'(o), 32'd5);
        drain_expect("drain3", 3, 7'd5, 7'd17, 7'd100, 7'd0);

        // Fill and overflow
        for (int k = 1; k <= 4; k++) step(1'b1, DW'(k), 1'b0);
        step(1'b1, 7'd9, 1'b0);
        check("fill_count", 32'(o_count), 32'd4);
        check("fill_ovf", 32'(overflow), 32'd1);
        drain_expect("drain_fill", 4, 7'd1, 7'd2, 7'd3, 7'd4);

        // Full with simultaneous push and pop
        do_reset(1);
        for (int k = 1; k <= 4; k++) step(1'b1, DW'(k), 1'b0);
        step(1'b1, 7'd8, 1'b1);
        check("fpp_ovf", 32'(overflow), 32'd0);
        check("fpp_count", 32'(o_count), 32'd4);
        drain_expect("drain_fpp", 4, 7'd2, 7'd3, 7'd4, 7'd8);

        // Pointer wrap and streaming
        for (int k = 0; k < 20; k++) begin
            step(1'b1, DW'(k), 1'b1);
            check("stream_o", 32'(o), 32'(k));
            check("stream_cnt_le1", 32'(o_count <= CW'(1)), 32'd1);
        end
        check("stream_ovf", 32'(overflow), 32'd0);
        step(1'b0, '0, 1'b1);

        // Reset mid-operation, max
        step(1'b1, 7'd40, 1'b0);
        step(1'b1, 7'd127, 1'b0);
        step(1'b1, 7'd3, 1'b0);
`ifdef SM_RESULT_FIFO_MAX_EN
        check("max_127", 32'(o_max), 32'd127);
`endif
        do_reset(1);
        check("mid_rst_count", 32'(o_count), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
`ifdef SM_RESULT_FIFO_MAX_EN
        check("mid_rst_max", 32'(o_max), 32'd0);
`endif

        // Random traffic with bursts of stall and occasional reset
        for (int n = 0; n < 3000; n++) begin
            logic dv;
            logic rdy;
            dv  = ($urandom_range(99) < 65);
            rdy = ((n / 64) % 3 == 1) ? ($urandom_range(99) < 15)
                                      : ($urandom_range(99) < 60);
            step(dv, DW'($urandom), rdy);
            if ($urandom_range(499) == 0) do_reset(1 + $urandom_range(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm_result_fifo.md
# sm_result_fifo

Downstream buffer for the 7-bit triple-sum results of the state-machine accumulator stage. It captures each `i_dval`-qualified result into a DEPTH-entry FIFO and presents the results to the consumer over a valid/ready handshake. It flags lost results with a sticky overflow bit. The accumulator has no backpressure, so this block absorbs consumer stalls.

## Interface
- `DW`, default 7: result width; matches the accumulator output.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `CW`, default `$clog2(DEPTH+1)`: occupancy counter width.

Ports:
- `clk`  in  1: clock; all state updates on posedge.
- `rst`  in  1: reset; synchronous and active-low. Sampled on posedge clk.
- `i_dval`  in  1: push strobe; one result per asserted cycle.
- `i`  in  DW: result data; valid when `i_dval`=1.
- `o_valid`  out  1: head entry is valid.
- `o_ready`  in  1: consumer accepts the head this cycle.
- `o`  out  DW: head entry data.
- `o_count`  out  CW: current occupancy, 0..DEPTH.
- `overflow`  out  1: sticky; a push was dropped since reset.
- `o_max`  out  DW: largest value accepted since reset. Present only with the macro; see Configuration.

## Operation
- Storage: DEPTH×DW register array, write pointer `wp`, read pointer `rp`, occupancy `cnt`. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- push = `i_dval`. pop = `o_valid && o_ready`.
- full = (`cnt`==DEPTH). empty = (`cnt`==0).
- A push is accepted when not full, or when full with a pop in the same cycle.
- Accepted push: `mem[wp]` is written with `i` and `wp` increments.
- Pop: `rp` increments.
- `cnt` update:
  - +1 on accepted push only.
  - −1 on pop only.
  - Unchanged when both occur or neither occurs.
- Dropped push (full and no pop): data is discarded, pointers and `cnt` are unchanged, and `overflow` is set to 1. It stays 1 until reset.
- Push while empty and `o_ready`=1 in the same cycle: the push is accepted and there is no pop, because `o_valid` was 0. There is no fall-through.
- Output signals:
  - `o_valid` = !empty.
  - `o` = `mem[rp]`. This is combinational from the registered array and pointer, so it is stable while `o_valid` is high and `o_ready` is low.
  - `o_count` = `cnt`.
- `o_ready` while `o_valid`=0 has no effect.
- Reset (`rst`=0 at posedge):
  - `wp`, `rp`, `cnt` ← 0.
  - `overflow` ← 0.
  - `o_max` ← 0.
  - `mem` contents are don't-care.
  - Outputs after reset: `o_valid`=0, `o_count`=0.
  - Reset asserted mid-stream discards all entries. Any `i_dval` in the reset cycle is ignored.

## Timing
- Push-to-visible latency: 1 cycle. With `i_dval`=1 at edge N, `o_valid`=1 and `o`=data after edge N.
- Throughput: one push and one pop per cycle, sustained, at any occupancy including full.
- Pop: the head advances at the edge where `o_valid && o_ready`. The new head, or `o_valid`=0, appears after that edge.
- `overflow` rises after the edge of the first dropped push.
- All outputs are glitch-free relative to clk.
- There is no combinational path from `i`/`i_dval` to any output. The only combinational path is `o_ready` → internal pop; `o_ready` does not reach any output combinationally.

## Configuration
- Macro: `SM_RESULT_FIFO_MAX_EN`.
- Defined:
  - The `o_max` port exists.
  - A DW-bit register updates on every accepted push: `o_max` ← max(`o_max`, `i`), unsigned compare.
  - Dropped pushes do not update it.
  - Reset value is 0.
- Undefined: the `o_max` port and its register are not generated. Benches must guard `o_max` checks with the same macro.

## Test plan
- Reset then idle:
  - After `rst`=0 for 2 cycles, then `rst`=1, expect `o_valid`=0, `o_count`=0, `overflow`=0.
- Push then drain with `o_ready`=0:
  - Push 5, 17, 100 on consecutive cycles; expect `o_count`=3 and `o`=5.
  - Then `o_ready`=1 for 3 cycles; expect `o` = 5, 17, 100 in order, then `o_valid`=0.
- Fill and overflow (DEPTH=4):
  - Push 1, 2, 3, 4, 9 with `o_ready`=0; expect `o_count`=4 and `overflow`=1.
  - Drain; expect 1, 2, 3, 4. Value 9 is never output.
- Full with simultaneous push and pop:
  - With the FIFO full of 1..4 and `o_ready`=1, push 8; expect no overflow and `o_count` to stay 4.
  - Drain; expect 2, 3, 4, 8.
- Pointer wrap and streaming:
  - 20 back-to-back pushes of 0..19 with `o_ready`=1 every cycle; expect outputs 0..19 with 1-cycle lag, `o_count` ≤ 1, and `overflow`=0.
- Reset mid-operation and max (macro defined):
  - Push 40, 127, 3; expect `o_max`=127.
  - Assert `rst` with `i_dval`=1; expect `o_count`=0, `o_max`=0, `overflow`=0 on the next cycle.
